// File: rtl/uart_frame_pkg.sv
// Shared types and constants for the UART frame parser and its timeout timer.
package uart_frame_pkg;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_GET_LEN     = 2'd1,
    ST_GET_PAYLOAD = 2'd2,
    ST_GET_CHK     = 2'd3
  } frame_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BAD_LEN = 2'd1,
    ERR_BAD_CHK = 2'd2,
    ERR_TIMEOUT = 2'd3
  } frame_err_t;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_parser_if.sv
// Byte stream in from uart_rx and payload/verdict stream out of the frame parser.
interface uart_frame_parser_if;
  // All strobes are single-cycle, no backpressure: a byte is accepted on every
  // cycle valid_in is high, and each output strobe is valid for exactly one cycle.
  logic [7:0] byte_in;
  logic       valid_in;
  logic [7:0] data_out;
  logic       data_valid_out;
  logic       data_last_out;
  logic [7:0] len_out;
  logic       frame_ok_out;
  logic       frame_err_out;
  logic [1:0] err_code_out;

  modport slave (
    input  byte_in, valid_in,
    output data_out, data_valid_out, data_last_out, len_out,
           frame_ok_out, frame_err_out, err_code_out
  );

  modport master (
    output byte_in, valid_in,
    input  data_out, data_valid_out, data_last_out, len_out,
           frame_ok_out, frame_err_out, err_code_out
  );
endinterface

// File: rtl/byte_timeout_timer.sv
// Inter-byte idle counter; expired_out is high for the cycle the count sits at TIMEOUT_CYCLES.
module byte_timeout_timer #(
  parameter int TIMEOUT_CYCLES = 100_000
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic enable_in,
  input  logic kick_in,
  output logic expired_out
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    // A byte on the expiry cycle wins over the timeout.
    expired_out = enable_in && !kick_in && (count_q == CW'(TIMEOUT_CYCLES));
    count_d     = count_q + 1'b1;
    if (!enable_in || kick_in || expired_out) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/uart_frame_parser.sv
// Frames SYNC/LEN/payload/CHK from a uart_rx byte stream; payload is cut-through, one verdict per frame.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEFAULT,
  parameter int         MAX_LEN        = 64,
  parameter int         TIMEOUT_CYCLES = 100_000
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  uart_frame_parser_if.slave   bus,
  output frame_state_t         state_dbg_out
);
  frame_state_t state_q, state_d;
  logic [7:0]   remaining_q, remaining_d;
  logic [7:0]   sum_q, sum_d;
  logic [7:0]   data_q, data_d;
  logic         data_valid_q, data_valid_d;
  logic         data_last_q, data_last_d;
  logic [7:0]   len_q, len_d;
  logic         ok_q, ok_d;
  logic         err_q, err_d;
  frame_err_t   err_code_q, err_code_d;
  logic [7:0]   sum_plus_byte;
  logic         expired;

  byte_timeout_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .enable_in   (state_q != ST_IDLE),
    .kick_in     (bus.valid_in),
    .expired_out (expired)
  );

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    sum_d         = sum_q;
    data_d        = data_q;
    data_valid_d  = 1'b0;
    data_last_d   = 1'b0;
    len_d         = len_q;
    ok_d          = 1'b0;
    err_d         = 1'b0;
    err_code_d    = err_code_q;
    sum_plus_byte = sum_q + bus.byte_in;

    if (bus.valid_in) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.byte_in == SYNC_BYTE) state_d = ST_GET_LEN;
        end
        ST_GET_LEN: begin
          // A rejected LEN byte is consumed; it is never reinterpreted as SYNC.
          if (bus.byte_in == 8'd0 || bus.byte_in > 8'(MAX_LEN)) begin
            err_d      = 1'b1;
            err_code_d = ERR_BAD_LEN;
            state_d    = ST_IDLE;
          end else begin
            len_d       = bus.byte_in;
            remaining_d = bus.byte_in;
            sum_d       = bus.byte_in;
            state_d     = ST_GET_PAYLOAD;
          end
        end
        ST_GET_PAYLOAD: begin
          data_d       = bus.byte_in;
          data_valid_d = 1'b1;
          sum_d        = sum_plus_byte;
          remaining_d  = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            data_last_d = 1'b1;
            state_d     = ST_GET_CHK;
          end
        end
        ST_GET_CHK: begin
          if (sum_plus_byte == 8'd0) begin
            ok_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_BAD_CHK;
          end
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (expired) begin
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = ST_IDLE;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      sum_q        <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      data_last_q  <= 1'b0;
      len_q        <= '0;
      ok_q         <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      sum_q        <= sum_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      data_last_q  <= data_last_d;
      len_q        <= len_d;
      ok_q         <= ok_d;
      err_q        <= err_d;
      err_code_q   <= err_code_d;
    end
  end

  assign bus.data_out       = data_q;
  assign bus.data_valid_out = data_valid_q;
  assign bus.data_last_out  = data_last_q;
  assign bus.len_out        = len_q;
  assign bus.frame_ok_out   = ok_q;
  assign bus.frame_err_out  = err_q;
  assign bus.err_code_out   = err_code_q;
  assign state_dbg_out      = state_q;
endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed-vector bench for uart_frame_parser with a cycle-stamped expected-event scoreboard.
module tb_uart_frame_parser;
  import uart_frame_pkg::*;

  localparam int T_CYC = 20;
  localparam int MAXL  = 64;
  // Event layout: [44:13] cycle, [12:11] kind (1 data, 2 ok, 3 err), [10] last, [9:8] code, [7:0] data
  localparam int W = 45;

  logic         clk;
  logic         rst_n;
  int           cyc;
  int           drv_cyc;
  int           checks;
  int           failures;
  frame_state_t state_dbg;
  logic [W-1:0] exp_q[$];

  uart_frame_parser_if bus ();

  uart_frame_parser #(.SYNC_BYTE(8'hA5), .MAX_LEN(MAXL), .TIMEOUT_CYCLES(T_CYC)) dut (
    .clk_in        (clk),
    .rst_n_in      (rst_n),
    .bus           (bus),
    .state_dbg_out (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int at, input logic [1:0] kind, input logic last,
                         input logic [1:0] code, input logic [7:0] d);
    exp_q.push_back({at[31:0], kind, last, code, d});
  endtask

  task automatic compare_ev(input string name, input logic [W-1:0] got);
    logic [W-1:0] exp;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected: got cyc=%0d ev=%0h expected none",
               name, got[44:13], got[12:0]);
    end else begin
      exp = exp_q.pop_front();
      if (got !== exp) begin
        failures++;
        $display("FAIL %s: got cyc=%0d ev=%0h expected cyc=%0d ev=%0h",
                 name, got[44:13], got[12:0], exp[44:13], exp[12:0]);
      end
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.frame_ok_out && bus.frame_err_out) begin
        checks++;
        failures++;
        $display("FAIL ok_err_both: got ok=1 err=1 expected at most one");
      end
      if (bus.data_last_out && !bus.data_valid_out) begin
        checks++;
        failures++;
        $display("FAIL last_without_valid: got last=1 valid=0 expected last only with valid");
      end
      if (bus.data_valid_out)
        compare_ev("data", {cyc[31:0], 2'd1, bus.data_last_out, 2'd0, bus.data_out});
      if (bus.frame_ok_out)
        compare_ev("ok", {cyc[31:0], 2'd2, 1'b0, 2'd0, 8'h00});
      if (bus.frame_err_out)
        compare_ev("err", {cyc[31:0], 2'd3, 1'b0, bus.err_code_out, 8'h00});
    end
  end

  // ---------------- drivers ----------------
  task automatic drive(input logic [7:0] b);
    @(negedge clk);
    bus.byte_in  = b;
    bus.valid_in = 1'b1;
    drv_cyc      = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.byte_in  = 8'h00;
      bus.valid_in = 1'b0;
    end
  endtask

  task automatic drv_data(input logic [7:0] b, input logic last);
    drive(b);
    push_ev(drv_cyc + 1, 2'd1, last, 2'd0, b);
  endtask

  task automatic drv_ok(input logic [7:0] b);
    drive(b);
    push_ev(drv_cyc + 1, 2'd2, 1'b0, 2'd0, 8'h00);
  endtask

  task automatic drv_err(input logic [7:0] b, input logic [1:0] code);
    drive(b);
    push_ev(drv_cyc + 1, 2'd3, 1'b0, code, 8'h00);
  endtask

  // ---------------- stimulus ----------------
  int t7e;

  initial begin
    checks       = 0;
    failures     = 0;
    drv_cyc      = 0;
    rst_n        = 1'b0;
    bus.byte_in  = 8'h00;
    bus.valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data_out", 32'(bus.data_out), 32'h0);
    check("rst_len_out", 32'(bus.len_out), 32'h0);
    check("rst_err_code", 32'(bus.err_code_out), 32'h0);
    check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    rst_n = 1'b1;
    idle(2);

    // Good frame: 03+11+22+33+97 = 0x100
    drive(8'hA5); drive(8'h03);
    drv_data(8'h11, 1'b0); drv_data(8'h22, 1'b0); drv_data(8'h33, 1'b1);
    drv_ok(8'h97);
    // Bad checksum immediately after, SYNC on the cycle after CHK
    drive(8'hA5); drive(8'h03);
    drv_data(8'h11, 1'b0); drv_data(8'h22, 1'b0); drv_data(8'h33, 1'b1);
    drv_err(8'h98, 2'd2);
    idle(2);
    check("len_after_good", 32'(bus.len_out), 32'h3);
    check("err_code_bad_chk", 32'(bus.err_code_out), 32'd2);

    // Bad lengths: zero and MAX_LEN+1; len_out must hold previous value
    drive(8'hA5); drv_err(8'h00, 2'd1);
    drive(8'hA5); drv_err(8'h41, 2'd1);
    idle(2);
    check("len_held_bad_len", 32'(bus.len_out), 32'h3);
    check("err_code_bad_len", 32'(bus.err_code_out), 32'd1);
    check("state_idle_after_bad_len", 32'(state_dbg), 32'(ST_IDLE));

    // A5 01 5A A5: 01+5A+A5 = 0x100
    drive(8'hA5); drive(8'h01); drv_data(8'h5A, 1'b1); drv_ok(8'hA5);
    idle(2);
    check("len_one", 32'(bus.len_out), 32'h1);
    check("err_code_held", 32'(bus.err_code_out), 32'd1);

    // LEN == MAX_LEN is legal: 64 zero bytes, 40+C0 = 0x100
    drive(8'hA5); drive(8'h40);
    for (int i = 0; i < MAXL; i++) drv_data(8'h00, i == MAXL - 1);
    drv_ok(8'hC0);
    idle(2);
    check("len_max", 32'(bus.len_out), 32'h40);

    // Junk in IDLE produces nothing
    drive(8'h00); drive(8'hFF); drive(8'h13);
    idle(3);
    check("state_idle_junk", 32'(state_dbg), 32'(ST_IDLE));

    // Timeout: error T+1 cycles after the edge capturing 7E
    drive(8'hA5); drive(8'h02); drv_data(8'h7E, 1'b0);
    t7e = drv_cyc;
    push_ev(t7e + T_CYC + 2, 2'd3, 1'b0, 2'd3, 8'h00);
    idle(T_CYC + 5);
    check("err_code_timeout", 32'(bus.err_code_out), 32'd3);
    check("state_idle_timeout", 32'(state_dbg), 32'(ST_IDLE));

    // Byte on the expiry cycle wins: 02+7E+10 = 0x90, CHK 70
    drive(8'hA5); drive(8'h02); drv_data(8'h7E, 1'b0);
    idle(T_CYC);
    drv_data(8'h10, 1'b1);
    drv_ok(8'h70);
    idle(T_CYC + 5);

    // Reset mid-frame: outputs clear asynchronously, no verdict
    drive(8'hA5); drive(8'h04); drv_data(8'h01, 1'b0); drv_data(8'h02, 1'b0);
    idle(1);
    #1;
    check("pre_rst_valid", 32'(bus.data_valid_out), 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(bus.data_valid_out), 32'h0);
    check("async_rst_data", 32'(bus.data_out), 32'h0);
    check("async_rst_len", 32'(bus.len_out), 32'h0);
    check("async_rst_err_code", 32'(bus.err_code_out), 32'h0);
    check("async_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    idle(2);
    rst_n = 1'b1;
    idle(T_CYC + 3);
    // A5 01 00 FF: 01+00+FF = 0x100
    drive(8'hA5); drive(8'h01); drv_data(8'h00, 1'b1); drv_ok(8'hFF);

    // SYNC value inside payload is data: 02+A5+A5 = 0x14C, CHK B4
    drive(8'hA5); drive(8'h02);
    drv_data(8'hA5, 1'b0); drv_data(8'hA5, 1'b1);
    drv_ok(8'hB4);
    idle(4);
    check("len_sync_payload", 32'(bus.len_out), 32'h2);

    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
